// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA timing generator with 2x2-scaled pixel coordinates
module vga_sync_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       active_area,
    output logic [8:0] pixel_x,
    output logic [8:0] pixel_y,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       active_q, active_d;
    logic [8:0] pixel_x_q, pixel_x_d;
    logic [8:0] pixel_y_q, pixel_y_d;
    logic       frame_start_q, frame_start_d;
    logic       line_start_q, line_start_d;

    always_comb begin
        h_count_d = h_count_q + 10'd1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = 10'd0;
            v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
        end
    end

    // Outputs decode the counters as they stand before the edge, so every
    // output lags the counter pair by exactly one clock.
    always_comb begin
        hsync_d       = !((h_count_q >= HS_START) && (h_count_q < HS_END));
        vsync_d       = !((v_count_q >= VS_START) && (v_count_q < VS_END));
        active_d      = (h_count_q < H_VIS) && (v_count_q < V_VIS);
        pixel_x_d     = active_d ? h_count_q[9:1] : 9'd0;
        pixel_y_d     = active_d ? v_count_q[9:1] : 9'd0;
        frame_start_d = (h_count_q == 10'd0) && (v_count_q == 10'd0);
        line_start_d  = (h_count_q == 10'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_count_q     <= 10'd0;
            v_count_q     <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            pixel_x_q     <= 9'd0;
            pixel_y_q     <= 9'd0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active_area = active_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - randomized bench against a linear-position timing model
`timescale 1ns/1ps
module tb_vga_sync_generator;

    localparam int HV = 40;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 10;
    localparam int VV = 20;
    localparam int VF = 3;
    localparam int VS = 2;
    localparam int VB = 5;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync, vsync, active_area, frame_start, line_start;
    logic [8:0] pixel_x, pixel_y;

    vga_sync_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .active_area(active_area),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .frame_start(frame_start),
        .line_start(line_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int cyc = 0;
    int last_fs = -1;
    int ls_cnt = 0;
    int vs_low = 0;
    int line_pos = 0;
    int hs_low = 0;
    bit line_seen = 0;
    logic prev_hs = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 1);
        chk({tag, "_vsync"}, 32'(vsync), 1);
        chk({tag, "_active"}, 32'(active_area), 0);
        chk({tag, "_pixel_x"}, 32'(pixel_x), 0);
        chk({tag, "_pixel_y"}, 32'(pixel_y), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_line_start"}, 32'(line_start), 0);
    endtask

    // Expected outputs for linear raster position p (0 = first pixel of frame).
    task automatic expect_at(input int p);
        int x, y, act;
        x   = p % HT;
        y   = p / HT;
        act = (x < HV && y < VV) ? 1 : 0;
        chk("hsync", 32'(hsync), (x >= HV + HF && x < HV + HF + HS) ? 0 : 1);
        chk("vsync", 32'(vsync), (y >= VV + VF && y < VV + VF + VS) ? 0 : 1);
        chk("active", 32'(active_area), act);
        chk("pixel_x", 32'(pixel_x), act ? x / 2 : 0);
        chk("pixel_y", 32'(pixel_y), act ? y / 2 : 0);
        chk("frame_start", 32'(frame_start), (p == 0) ? 1 : 0);
        chk("line_start", 32'(line_start), (x == 0) ? 1 : 0);
        if (active_area === 1'b1)
            chk("fb_addr_range", 32'(int'(pixel_y) * (HV / 2) + int'(pixel_x) < (HV / 2) * (VV / 2)), 1);
        if (hsync === 1'b0 || vsync === 1'b0)
            chk("blank_in_sync", 32'(active_area), 0);
    endtask

    task automatic clear_tracking();
        pos = 0; last_fs = -1; ls_cnt = 0; vs_low = 0;
        line_pos = 0; hs_low = 0; line_seen = 0; prev_hs = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        expect_at(pos);
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
                chk("fs_gap", 32'(cyc - last_fs), FRAME);
                chk("ls_per_frame", 32'(ls_cnt), VT);
                chk("vs_low_per_frame", 32'(vs_low), VS * HT);
            end
            last_fs = cyc; ls_cnt = 0; vs_low = 0;
        end
        if (line_start === 1'b1) begin
            if (line_seen) chk("hs_width", 32'(hs_low), HS);
            line_seen = 1; line_pos = 0; hs_low = 0;
            ls_cnt++;
        end else begin
            line_pos++;
        end
        if (hsync === 1'b0) begin
            hs_low++;
            if (prev_hs === 1'b1 && line_seen) chk("hs_offset", 32'(line_pos), HV + HF);
        end
        if (vsync === 1'b0) vs_low++;
        prev_hs = hsync;
        pos = (pos + 1) % FRAME;
        cyc++;
    endtask

    task automatic async_reset_after(input int run);
        repeat (run) step();
        @(posedge clk);
        #($urandom_range(1, 3));
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        reset = 1'b1;
        clear_tracking();
        step();
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 check_reset_vals("rst_no_clk");
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("rst_init");
        end
        reset = 1'b1;
        clear_tracking();
        repeat (2 * FRAME + 5) step();
        async_reset_after(15 * HT + 25);
        repeat (4) async_reset_after(int'($urandom_range(1, 2 * FRAME)));
        repeat (FRAME + 5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, visible columns per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit, 25 MHz pixel clock; the only clock in the block.
REQ-010 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-011 The block SHALL have port hsync, output, 1 bit, horizontal sync, active-low.
REQ-012 The block SHALL have port vsync, output, 1 bit, vertical sync, active-low.
REQ-013 The block SHALL have port active_area, output, 1 bit, high while the current pixel is visible.
REQ-014 The block SHALL have port pixel_x, output, 9 bits, visible column divided by 2 (range 0..319).
REQ-015 The block SHALL have port pixel_y, output, 9 bits, visible line divided by 2 (range 0..239).
REQ-016 The block SHALL have port frame_start, output, 1 bit, one-cycle pulse at the first pixel of each frame.
REQ-017 The block SHALL have port line_start, output, 1 bit, one-cycle pulse at column 0 of every line, including blanking lines.

Function
REQ-018 Internal h_count (10 bits) SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the four H parameters, 800) and increment every clk edge.
REQ-019 At h_count = H_TOTAL-1, h_count SHALL wrap to 0 and v_count (10 bits) SHALL advance.
REQ-020 v_count SHALL count 0..V_TOTAL-1 (525) and wrap to 0 when h_count and v_count are both at terminal value on the same edge.
REQ-021 All outputs SHALL be registered and decoded from the counter values before the edge, giving a fixed one-cycle latency from counter state to output.
REQ-022 hsync SHALL be 0 iff h_count is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 at defaults).
REQ-023 vsync SHALL be 0 iff v_count is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491 at defaults), over whole lines.
REQ-024 active_area SHALL be 1 iff h_count < H_VISIBLE and v_count < V_VISIBLE.
REQ-025 pixel_x SHALL equal h_count[9:1] and pixel_y SHALL equal v_count[9:1] while active_area = 1.
REQ-026 pixel_x and pixel_y SHALL both be 0 while active_area = 0.
REQ-027 This 2x2 scaling SHALL make pixel_y*320+pixel_x fit the downstream 17-bit frame-buffer address.
REQ-028 frame_start SHALL be 1 for exactly one cycle per frame, coincident with active_area rising at pixel (0,0).
REQ-029 line_start SHALL be 1 for exactly one cycle when the decoded h_count = 0.
REQ-030 The horizontal and vertical phases (VISIBLE, FRONT, SYNC, BACK) SHALL be pure decodes of the counters, with no separate state register able to desynchronise from them.

Reset
REQ-031 While reset = 0, h_count and v_count SHALL be 0.
REQ-032 While reset = 0, outputs SHALL be: hsync = 1, vsync = 1, active_area = 0, pixel_x = 0, pixel_y = 0, frame_start = 0, line_start = 0.
REQ-033 Assertion of reset SHALL take effect immediately, without a clock edge, including mid-frame.
REQ-034 On the first clk edge after release, outputs SHALL decode counter (0,0): active_area = 1, frame_start = 1, line_start = 1.

Verification
REQ-035 Reset then release -> first edge: active_area = 1, frame_start = 1, line_start = 1, pixel_x = 0, pixel_y = 0; hsync = 1, vsync = 1.
REQ-036 Run one line -> active_area high 640 cycles, then low 160 cycles; hsync low exactly 96 cycles starting 656 cycles after line_start; pixel_x steps 0,0,1,1,...,319,319.
REQ-037 Run one frame -> 525 line_start pulses; vsync low for exactly 1600 cycles, starting on line 490; pixel_y = 239 on lines 478 and 479, and 0 on blanking lines.
REQ-038 Run two frames -> frame_start pulses exactly 420000 cycles apart; no active_area on lines 480..524.
REQ-039 Assert reset at line 300, column 400, for 3 cycles asynchronously -> outputs reach reset values before the next edge; after release, REQ-035 behaviour repeats.
REQ-040 Every active cycle -> the checker SHALL assert pixel_y*320+pixel_x < 76800 and active_area = 0 whenever hsync = 0 or vsync = 0.
